maze_player_tracker: RTL and testbench



---
 rtl/maze_pkg.sv | 37 +++
 rtl/maze_player_tracker_if.sv | 30 +++
 rtl/maze_cell_hit.sv | 31 +++
 rtl/maze_player_tracker.sv | 160 ++++++++++++++++
 tb/tb_maze_player_tracker.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared grid geometry, checkpoint order and state type for the maze blocks.
// Used by maze_player_tracker and maze_cell_hit (and reusable by the renderer).
package maze_pkg;

  localparam int GRID_COLS = 18;
  localparam int GRID_ROWS = 11;
  localparam int CELL_PX   = 5;
  localparam int GRID_Y0   = 9;
  localparam int N_CP      = 5;

  localparam logic [7:0] CP0 = 8'd31;
  localparam logic [7:0] CP1 = 8'd37;
  localparam logic [7:0] CP2 = 8'd113;
  localparam logic [7:0] CP3 = 8'd139;
  localparam logic [7:0] CP4 = 8'd178;

  localparam logic [7:0] COUNTER_HIT = 8'd255;

  typedef enum logic [1:0] {
    PLAY,
    HIT,
    WIN
  } state_e;

  // Cell of the idx-th checkpoint; out-of-range idx never matches a cell.
  function automatic logic [7:0] cp_cell(input logic [2:0] idx);
    case (idx)
      3'd0:    return CP0;
      3'd1:    return CP1;
      3'd2:    return CP2;
      3'd3:    return CP3;
      3'd4:    return CP4;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/maze_player_tracker_if.sv
// Bundle of game inputs, pixel coordinates and tracker outputs.
// master drives buttons/tick/pixel/maze; slave is the tracker.
interface maze_player_tracker_if;

  logic         move_tick;
  logic         btn_up;
  logic         btn_down;
  logic         btn_left;
  logic         btn_right;
  logic [6:0]   x;
  logic [5:0]   y;
  logic [197:0] mazestate;
  logic [7:0]   counter;
  logic [15:0]  redsquare;
  logic [7:0]   player_cell;
  logic         win;

  modport master (
    output move_tick, btn_up, btn_down, btn_left, btn_right,
    output x, y, mazestate,
    input  counter, redsquare, player_cell, win
  );

  modport slave (
    input  move_tick, btn_up, btn_down, btn_left, btn_right,
    input  x, y, mazestate,
    output counter, redsquare, player_cell, win
  );

endinterface

// File: rtl/maze_cell_hit.sv
// Flags whether pixel (x_i,y_i) lies inside the grid cell at (row_i,col_i).
// Ports: x_i/y_i pixel, row_i/col_i cell, hit_o inside-cell flag.
module maze_cell_hit
  import maze_pkg::*;
(
  input  logic [6:0] x_i,
  input  logic [5:0] y_i,
  input  logic [3:0] row_i,
  input  logic [4:0] col_i,
  output logic       hit_o
);

  localparam logic [7:0] PX  = 8'(CELL_PX);
  localparam logic [7:0] Y0  = 8'(GRID_Y0);
  localparam logic [7:0] SPN = 8'(CELL_PX - 1);

  logic [7:0] x0;
  logic [7:0] y0;
  logic [7:0] xw;
  logic [7:0] yw;

  always_comb begin
    x0 = 8'(col_i) * PX;
    y0 = Y0 + 8'(row_i) * PX;
    xw = {1'b0, x_i};
    yw = {2'b0, y_i};
    hit_o = (xw >= x0) && (xw <= x0 + SPN)
         && (yw >= y0) && (yw <= y0 + SPN);
  end

endmodule

// File: rtl/maze_player_tracker.sv
// Player position, wall-hit and checkpoint tracker feeding the renderer.
// Ports: CLK, RESET (sync, active-high), bus (slave). Macro: MAZE_PLAYER_BLINK_EN.
module maze_player_tracker
  import maze_pkg::*;
#(
  parameter int unsigned  START_CELL    = 19,
  parameter int unsigned  HIT_TICKS     = 32,
  parameter logic [15:0]  PLAYER_COLOUR = 16'hF800
) (
  input  logic                 CLK,
  input  logic                 RESET,
  maze_player_tracker_if.slave bus
);

  localparam int TW = (HIT_TICKS > 8) ? $clog2(HIT_TICKS) : 3;
  localparam logic [TW-1:0] TMR_LAST = TW'(HIT_TICKS - 1);
  localparam logic [3:0] START_ROW = 4'(START_CELL / GRID_COLS);
  localparam logic [4:0] START_COL = 5'(START_CELL % GRID_COLS);
  localparam logic [3:0] ROW_MAX = 4'(GRID_ROWS - 1);
  localparam logic [4:0] COL_MAX = 5'(GRID_COLS - 1);
  localparam logic [7:0] COLS8 = 8'(GRID_COLS);

  state_e        state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic [2:0]    cp_q, cp_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          win_q, win_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [15:0]   red_q, red_d;

  logic [3:0] btn;
  logic       one_hot;
  logic       in_grid;
  logic [3:0] trow;
  logic [4:0] tcol;
  logic [7:0] tidx;
  logic       in_cell;
  logic       show;

  maze_cell_hit u_hit (
    .x_i   (bus.x),
    .y_i   (bus.y),
    .row_i (row_q),
    .col_i (col_q),
    .hit_o (in_cell)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cp_d    = cp_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    tmr_d   = tmr_q;
    in_grid = 1'b0;
    trow    = row_q;
    tcol    = col_q;

    btn = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
    one_hot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);

    if (one_hot) begin
      unique case (1'b1)
        btn[3]: begin
          in_grid = row_q != 4'd0;
          trow    = row_q - 4'd1;
        end
        btn[2]: begin
          in_grid = row_q != ROW_MAX;
          trow    = row_q + 4'd1;
        end
        btn[1]: begin
          in_grid = col_q != 5'd0;
          tcol    = col_q - 5'd1;
        end
        btn[0]: begin
          in_grid = col_q != COL_MAX;
          tcol    = col_q + 5'd1;
        end
      endcase
    end
    tidx = 8'(tcol) + 8'(trow) * COLS8;

    unique case (state_q)
      PLAY: begin
        if (bus.move_tick && one_hot && in_grid) begin
          if (!bus.mazestate[tidx]) begin
            state_d = HIT;
            cnt_d   = COUNTER_HIT;
            tmr_d   = '0;
          end else begin
            row_d = trow;
            col_d = tcol;
            if (tidx == cp_cell(cp_q)) begin
              cp_d  = cp_q + 3'd1;
              cnt_d = cnt_q + 8'd1;
              if (cp_q == 3'(N_CP - 1)) begin
                state_d = WIN;
                win_d   = 1'b1;
              end
            end
          end
        end
      end
      HIT: begin
        if (bus.move_tick) begin
          if (tmr_q == TMR_LAST) begin
            state_d = PLAY;
            row_d   = START_ROW;
            col_d   = START_COL;
            cnt_d   = 8'd0;
            cp_d    = 3'd0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      WIN: ;
      default: state_d = PLAY;
    endcase

`ifdef MAZE_PLAYER_BLINK_EN
    // Visible for 4 ticks, hidden for 4, while the hit timer runs.
    show = (state_q != HIT) || !tmr_q[2];
`else
    show = state_q != HIT;
`endif
    red_d = (in_cell && show) ? PLAYER_COLOUR : 16'hFFFF;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= PLAY;
      row_q   <= START_ROW;
      col_q   <= START_COL;
      cp_q    <= 3'd0;
      cnt_q   <= 8'd0;
      win_q   <= 1'b0;
      tmr_q   <= '0;
      red_q   <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cp_q    <= cp_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      tmr_q   <= tmr_d;
      red_q   <= red_d;
    end
  end

  assign bus.counter     = cnt_q;
  assign bus.win         = win_q;
  assign bus.redsquare   = red_q;
  assign bus.player_cell = 8'(col_q) + 8'(row_q) * COLS8;

endmodule

// File: tb/tb_maze_player_tracker.sv
// Randomized + directed bench for maze_player_tracker against a cell-index model.
// Reports one summary line of passed/total checks.
module tb_maze_player_tracker;

  localparam int START = 19;
  localparam int HITN  = 32;
  localparam int UP = 8, DN = 4, LF = 2, RT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maze_player_tracker_if bus();

  maze_player_tracker #(
    .START_CELL    (START),
    .HIT_TICKS     (HITN),
    .PLAYER_COLOUR (16'hF800)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_chk  = 0;

  int m_cell, m_cnt, m_win, m_st, m_cp, m_tmr;
  int m_red;
  int cps[5] = '{31, 37, 113, 139, 178};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_step();
    int r, c, tr, tc, t, px, py;
    bit inc, show;
    logic [3:0] b;
    r  = m_cell / 18;
    c  = m_cell % 18;
    px = int'(bus.x);
    py = int'(bus.y);
    inc = (px < 90) && (px / 5 == c) && (py >= 9) && ((py - 9) / 5 == r);
`ifdef MAZE_PLAYER_BLINK_EN
    show = (m_st != 1) || (((m_tmr >> 2) & 1) == 0);
`else
    show = m_st != 1;
`endif
    if (rst) begin
      m_cell = START; m_cnt = 0; m_win = 0;
      m_cp = 0; m_st = 0; m_tmr = 0; m_red = 'hFFFF;
      return;
    end
    m_red = (inc && show) ? 'hF800 : 'hFFFF;
    if (!bus.move_tick) return;
    b = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
    if (m_st == 0 && $countones(b) == 1) begin
      tr = r; tc = c;
      if (b[3]) tr = r - 1;
      if (b[2]) tr = r + 1;
      if (b[1]) tc = c - 1;
      if (b[0]) tc = c + 1;
      if (tr >= 0 && tr <= 10 && tc >= 0 && tc <= 17) begin
        t = tc + 18 * tr;
        if (!bus.mazestate[t]) begin
          m_st = 1; m_cnt = 255; m_tmr = 0;
        end else begin
          m_cell = t;
          if (m_cp < 5 && t == cps[m_cp]) begin
            m_cp++;
            m_cnt = m_cp;
            if (m_cp == 5) begin
              m_st = 2; m_win = 1;
            end
          end
        end
      end
    end else if (m_st == 1) begin
      if (m_tmr == HITN - 1) begin
        m_cell = START; m_cnt = 0; m_cp = 0; m_st = 0;
      end else begin
        m_tmr++;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("counter", 32'(bus.counter), 32'(m_cnt));
    chk("cell", 32'(bus.player_cell), 32'(m_cell));
    chk("win", 32'(bus.win), 32'(m_win));
    chk("red", 32'(bus.redsquare), 32'(m_red));
  endtask

  task automatic set_btn(input int b);
    bus.btn_up    = b[3];
    bus.btn_down  = b[2];
    bus.btn_left  = b[1];
    bus.btn_right = b[0];
  endtask

  task automatic press(input int b);
    set_btn(b);
    bus.move_tick = 1'b1;
    cyc();
    bus.move_tick = 1'b0;
    set_btn(0);
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    bus.move_tick = 1'b0;
    set_btn(0);
    bus.x = '0;
    bus.y = '0;
    bus.mazestate = '1;
    cyc();
    do_reset();

    bus.x = 7'd5;
    bus.y = 6'd14;
    cyc();
    chk("t1_red", 32'(bus.redsquare), 32'hF800);
    chk("t1_cell", 32'(bus.player_cell), 32'd19);
    chk("t1_cnt", 32'(bus.counter), 32'd0);

    bus.mazestate = '0;
    bus.mazestate[19] = 1'b1;
    bus.mazestate[20] = 1'b1;
    press(RT);
    chk("t2_cell", 32'(bus.player_cell), 32'd20);
    chk("t2_cnt", 32'(bus.counter), 32'd0);

    do_reset();
    bus.mazestate = '1;
    bus.mazestate[1] = 1'b0;
    press(UP);
    chk("t3_cnt", 32'(bus.counter), 32'd255);
    chk("t3_cell", 32'(bus.player_cell), 32'd19);
    for (int i = 0; i < HITN - 1; i++) press(RT);
    chk("t3_hold", 32'(bus.counter), 32'd255);
    press(0);
    chk("t3_cnt2", 32'(bus.counter), 32'd0);
    chk("t3_cell2", 32'(bus.player_cell), 32'd19);

    bus.mazestate = '1;
    do_reset();
    press(DN);
    chk("t4_ooo", 32'(bus.counter), 32'd0);
    press(UP);
    for (int i = 0; i < 12; i++) press(RT);
    chk("t4_cp1", 32'(bus.counter), 32'd1);
    press(DN);
    for (int i = 0; i < 12; i++) press(LF);
    chk("t4_cp2", 32'(bus.counter), 32'd2);

    do_reset();
    for (int i = 0; i < 12; i++) press(RT);
    press(DN);
    for (int i = 0; i < 12; i++) press(LF);
    for (int i = 0; i < 4; i++) press(DN);
    for (int i = 0; i < 4; i++) press(RT);
    press(DN);
    for (int i = 0; i < 8; i++) press(RT);
    for (int i = 0; i < 2; i++) press(DN);
    for (int i = 0; i < 3; i++) press(RT);
    chk("t5_cnt", 32'(bus.counter), 32'd5);
    chk("t5_win", 32'(bus.win), 32'd1);
    press(LF);
    press(UP);
    chk("t5_frz", 32'(bus.player_cell), 32'd178);

    do_reset();
    press(LF | UP);
    chk("t6_two", 32'(bus.player_cell), 32'd19);
    press(LF);
    press(LF);
    chk("t6_edge", 32'(bus.player_cell), 32'd18);
    chk("t6_nohit", 32'(bus.counter), 32'd0);
    bus.mazestate[0] = 1'b0;
    press(UP);
    chk("t6_hit", 32'(bus.counter), 32'd255);
    press(0);
    press(0);
    rst = 1'b1;
    cyc();
    chk("t6_rcnt", 32'(bus.counter), 32'd0);
    chk("t6_rcell", 32'(bus.player_cell), 32'd19);
    rst = 1'b0;

    for (int i = 0; i < 198; i++) bus.mazestate[i] = $urandom_range(0, 99) < 88;
    for (int n = 0; n < 4000; n++) begin
      int r, b;
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0)
        for (int i = 0; i < 198; i++)
          bus.mazestate[i] = $urandom_range(0, 99) < 88;
      bus.move_tick = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 7);
      case (r)
        4:       b = 0;
        5:       b = (1 << $urandom_range(0, 3)) | (1 << $urandom_range(0, 3));
        default: b = 1 << $urandom_range(0, 3);
      endcase
      set_btn(b);
      if ($urandom_range(0, 1) == 0) begin
        bus.x = 7'((m_cell % 18) * 5 + $urandom_range(0, 5));
        bus.y = 6'(9 + (m_cell / 18) * 5 + $urandom_range(0, 5) - 1);
      end else begin
        bus.x = 7'($urandom_range(0, 95));
        bus.y = 6'($urandom_range(0, 63));
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
